// File: rtl/sync_tx_arbiter.sv
// Source-domain round-robin arbiter feeding a 4-bit enable-qualified clock crossing.
// Each accepted word is held with data_en high for HOLD_CYC cycles, then held with data_en low for GAP_CYC cycles.
module sync_tx_arbiter #(
    parameter int NREQ     = 3,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 4
) (
    input  logic                clk_a,
    input  logic                arstn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [3:0]          data_in,
    output logic                data_en,
    output logic [1:0]          grant_id,
    output logic                busy
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYC - 1);
    localparam logic [1:0] LAST_RST  = 2'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [1:0] last;

    logic       win_vld;
    logic [1:0] win_id;
    logic [3:0] win_word;
    logic       accept;
    int         idx;

    // Rotating search starting just after the previous winner.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = 2'd0;
        win_word = 4'd0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!win_vld && req_valid[idx]) begin
                win_vld  = 1'b1;
                win_id   = 2'(idx);
                win_word = req_data[4*idx +: 4];
            end
        end
    end

    assign accept = (state == IDLE) && win_vld;

    // State register
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Output logic: combinational accept strobe
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (int'(win_id) == i);
        end
    end

    // Registered crossing outputs; data_in only moves on an accept so it stays stable through the gap.
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            data_in  <= 4'd0;
            data_en  <= 1'b0;
            grant_id <= 2'd0;
            busy     <= 1'b0;
            last     <= LAST_RST;
        end else begin
            data_en <= (state_nxt == HOLD);
            busy    <= (state_nxt != IDLE);
            if (accept) begin
                data_in  <= win_word;
                grant_id <= win_id;
                last     <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Directed bench for sync_tx_arbiter: default timing instance plus a HOLD=1/GAP=1 instance.
module tb_sync_tx_arbiter;

    logic        clk_a;
    logic        arstn;
    logic [2:0]  req_valid;
    logic [11:0] req_data;
    logic [2:0]  req_ready;
    logic [3:0]  data_in;
    logic        data_en;
    logic [1:0]  grant_id;
    logic        busy;

    logic [2:0]  req_valid2;
    logic [11:0] req_data2;
    logic [2:0]  req_ready2;
    logic [3:0]  data_in2;
    logic        data_en2;
    logic [1:0]  grant_id2;
    logic        busy2;

    int n_checks;
    int n_fail;

    sync_tx_arbiter #(.NREQ(3), .HOLD_CYC(4), .GAP_CYC(4)) dut (
        .clk_a(clk_a), .arstn(arstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .data_in(data_in), .data_en(data_en),
        .grant_id(grant_id), .busy(busy)
    );

    sync_tx_arbiter #(.NREQ(3), .HOLD_CYC(1), .GAP_CYC(1)) dut_min (
        .clk_a(clk_a), .arstn(arstn), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .data_in(data_in2), .data_en(data_en2),
        .grant_id(grant_id2), .busy(busy2)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    task automatic step();
        @(posedge clk_a);
        #1;
    endtask

    task automatic apply_reset();
        arstn     = 1'b0;
        req_valid = 3'b000;
        step();
        step();
        arstn = 1'b1;
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b required 0 within 50 cycles", busy);
        end
    endtask

    task automatic test_reset();
        arstn      = 1'b0;
        req_valid  = 3'b000;
        req_data   = 12'h000;
        req_valid2 = 3'b000;
        req_data2  = 12'h000;
        step();
        step();
        n_checks++;
        if ({data_in, data_en, grant_id, busy, req_ready} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: din=%h en=%b gid=%0d busy=%b rdy=%b required all 0",
                     data_in, data_en, grant_id, busy, req_ready);
        end
        arstn = 1'b1;
        #1;
    endtask

    task automatic test_single();
        req_data  = 12'h0A0;
        req_valid = 3'b010;
        #1;
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL single_ready: req_ready=%b required 010", req_ready);
        end
        step();
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL single_ready_once: req_ready=%b required 000", req_ready);
        end
        req_valid = 3'b000;
        n_checks++;
        if (data_in !== 4'hA || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL single_word: din=%h gid=%0d required A/1", data_in, grant_id);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (data_en !== (i < 4) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_timing[%0d]: en=%b busy=%b required %b/1", i, data_en, busy, (i < 4));
            end
            step();
        end
        n_checks++;
        if (busy !== 1'b0 || data_en !== 1'b0 || data_in !== 4'hA) begin
            n_fail++;
            $display("FAIL single_after: busy=%b en=%b din=%h required 0/0/A", busy, data_en, data_in);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [4];
        logic [3:0] exp_w  [4];
        int n;
        int prev;
        logic acc;
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_w  = '{4'h1, 4'h2, 4'h3, 4'h1};
        apply_reset();
        req_data  = 12'h321;
        req_valid = 3'b111;
        n = 0;
        prev = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            #1;
            acc = 1'b0;
            if (busy) begin
                n_checks++;
                if (req_ready !== 3'b000) begin
                    n_fail++;
                    $display("FAIL rr_busy_ready: cycle %0d req_ready=%b required 000", c, req_ready);
                end
            end else begin
                acc = 1'b1;
                n_checks++;
                if (req_ready !== (3'b001 << exp_id[n])) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: req_ready=%b required %b", n, req_ready, 3'b001 << exp_id[n]);
                end
                if (n > 0) begin
                    n_checks++;
                    if (c - prev != 9) begin
                        n_fail++;
                        $display("FAIL rr_period[%0d]: spacing=%0d required 9", n, c - prev);
                    end
                end
                prev = c;
            end
            step();
            if (acc) begin
                n_checks++;
                if (data_in !== exp_w[n] || grant_id !== exp_id[n]) begin
                    n_fail++;
                    $display("FAIL rr_word[%0d]: din=%h gid=%0d required %h/%0d",
                             n, data_in, grant_id, exp_w[n], exp_id[n]);
                end
                n++;
            end
        end
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL rr_count: accepts=%0d required 4", n);
        end
        req_valid = 3'b000;
        wait_idle();
    endtask

    task automatic test_fairness();
        apply_reset();
        req_data  = 12'h321;
        req_valid = 3'b010;
        #1;
        step();
        req_valid = 3'b000;
        wait_idle();
        req_valid = 3'b011;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL fair_ready: req_ready=%b required 001", req_ready);
        end
        step();
        n_checks++;
        if (grant_id !== 2'd0 || data_in !== 4'h1) begin
            n_fail++;
            $display("FAIL fair_grant: gid=%0d din=%h required 0/1", grant_id, data_in);
        end
        req_valid = 3'b000;
        wait_idle();
    endtask

    task automatic test_min_timing();
        req_data2  = 12'h500;
        req_valid2 = 3'b100;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req_ready2 != 3'b000) break;
            step();
        end
        n_checks++;
        if (req_ready2 !== 3'b100) begin
            n_fail++;
            $display("FAIL min_first_ready: req_ready=%b required 100", req_ready2);
        end
        step();
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (data_en2 !== (i % 3 == 0) || grant_id2 !== 2'd2 || data_in2 !== 4'h5) begin
                n_fail++;
                $display("FAIL min_pattern[%0d]: en=%b gid=%0d din=%h required %b/2/5",
                         i, data_en2, grant_id2, data_in2, (i % 3 == 0));
            end
            n_checks++;
            if (req_ready2 !== ((i % 3 == 2) ? 3'b100 : 3'b000)) begin
                n_fail++;
                $display("FAIL min_ready[%0d]: req_ready=%b", i, req_ready2);
            end
            step();
        end
        req_valid2 = 3'b000;
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        req_data  = 12'h321;
        req_valid = 3'b100;
        #1;
        step();
        step();
        n_checks++;
        if (data_en !== 1'b1 || data_in !== 4'h3 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL midhold_pre: en=%b din=%h gid=%0d required 1/3/2", data_en, data_in, grant_id);
        end
        #2;
        arstn = 1'b0;
        #1;
        n_checks++;
        if ({data_in, data_en, grant_id, busy} !== 8'd0) begin
            n_fail++;
            $display("FAIL midhold_async: din=%h en=%b gid=%0d busy=%b required all 0",
                     data_in, data_en, grant_id, busy);
        end
        req_valid = 3'b111;
        step();
        arstn = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL midhold_restart: req_ready=%b required 001", req_ready);
        end
        step();
        req_valid = 3'b000;
        n_checks++;
        if (grant_id !== 2'd0 || data_in !== 4'h1 || data_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midhold_grant: gid=%0d din=%h en=%b required 0/1/1", grant_id, data_in, data_en);
        end
    endtask

    task automatic test_withdrawn();
        step();
        req_valid = 3'b010;
        step();
        req_valid = 3'b000;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (req_ready !== 3'b000 || data_in !== 4'h1 || grant_id !== 2'd0) begin
                n_fail++;
                $display("FAIL withdrawn[%0d]: rdy=%b din=%h gid=%0d required 000/1/0",
                         i, req_ready, data_in, grant_id);
            end
            step();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_min_timing();
        test_reset_mid_hold();
        test_withdrawn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
